countdown_led: RTL and testbench
================================

COUNTDOWN_LED -- requirements
Module: countdown_led

Interface
REQ-001 Parameter LED_W, default 16: number of LED outputs.
REQ-002 Parameter TICK_CYCLES, default 1000: clk cycles per countdown step (1 s at 1 kHz).
REQ-003 Parameter FLASH_HALF, default 250: clk cycles per flash half-period.
REQ-004 The port list SHALL have one clock; reset is synchronous and active-high; ports: clk  in  1  1 kHz system clock, sole clock.
REQ-005 reset_n  in  1  synchronous reset, active-high (1 = reset, despite the suffix).
REQ-006 ring  in  1  alarm trigger; level, start on rising edge.
REQ-007 led  out  LED_W  countdown bar / flash pattern.
REQ-008 busy  out  1  high while not IDLE.
REQ-009 done  out  1  one-cycle pulse at sequence end.

Function
REQ-010 The block SHALL register ring into ring_d each cycle; start = ring & ~ring_d; a held-high ring SHALL NOT retrigger.
REQ-011 States SHALL be IDLE, COUNT, FLASH; IDLE: led = 0, busy = 0.
REQ-012 On start in cycle N (any state), the next edge SHALL set state COUNT, led all ones, tick counter 0, flash counters 0 (restart mid-COUNT/FLASH).
REQ-013 In COUNT the tick counter SHALL run 0..TICK_CYCLES-1; at TICK_CYCLES-1 it wraps to 0 and led <= {0, led[LED_W-1:1]} (bar shrinks from MSB).
REQ-014 First shift SHALL occur exactly TICK_CYCLES cycles after led becomes all ones.
REQ-015 A step with led == 1 SHALL instead enter FLASH with led all ones and flash counters cleared.
REQ-016 In FLASH a half-period counter SHALL run 0..FLASH_HALF-1; half-period boundaries 1..5 toggle led (on, off, on, off, on, off = 3 blinks).
REQ-017 At boundary 6 the block SHALL go IDLE, led = 0, done = 1 for that one cycle.
REQ-018 Sequence length start-to-done SHALL be LED_W*TICK_CYCLES + 6*FLASH_HALF cycles after led first all ones.
REQ-019 busy SHALL be registered, equal to (state != IDLE), updating with state.
REQ-020 start coinciding with a step or flash boundary SHALL win (restart).
REQ-021 All counters SHALL be sized ceil(log2(param)) and never exceed param-1.

Reset
REQ-022 While reset_n = 1 at a clk edge: state IDLE, led = 0, busy = 0, done = 0, ring_d = 0, all counters 0.
REQ-023 Reset mid-COUNT/FLASH SHALL abort immediately; ring high on the first cycle after reset SHALL count as a rising edge.
REQ-024 Reset SHALL take priority over start.

Structure
REQ-025 Package countdown_led_pkg SHALL hold the state enum and default parameter constants.
REQ-026 One sub-module countdown_tick (modulo-N counter with clear input and wrap pulse) SHALL be instantiated for both step and flash timing.
REQ-027 All logic SHALL be single-clock synchronous; no derived clocks.

Verification (LED_W = 4, TICK_CYCLES = 4, FLASH_HALF = 2)
REQ-028 Reset 5 cycles, ring low -> led = 0, busy = 0, done = 0 throughout.
REQ-029 ring 1-cycle pulse -> next cycle led = 1111, busy = 1; then 0111, 0011, 0001 at 4-cycle spacing; 4 cycles later led = 1111 (FLASH).
REQ-030 Continue -> led 1111, 0000, 1111, 0000, 1111, 0000 each 2 cycles; then done = 1 one cycle, busy = 0, led = 0; total 28 cycles after led first 1111.
REQ-031 ring held high 50 cycles -> only one sequence; no restart.
REQ-032 Second ring pulse while led = 0011 -> next cycle led = 1111, tick counter restarted.
REQ-033 reset_n = 1 during FLASH -> next edge led = 0, busy = 0, no done pulse.

Source files
------------

// File: rtl/countdown_led_pkg.sv
// Shared definitions for the countdown LED alarm.
//   state_t          : top-level sequence states (IDLE, COUNT, FLASH)
//   DEF_*            : default parameter values for countdown_led
//   FLASH_BOUNDS     : number of flash half-period boundaries per sequence
//   cnt_width()      : counter width for a modulo-n counter (at least 1 bit)
package countdown_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  localparam int DEF_LED_W       = 16;
  localparam int DEF_TICK_CYCLES = 1000;
  localparam int DEF_FLASH_HALF  = 250;

  // Boundaries 1..5 toggle the bar, boundary 6 ends the sequence.
  localparam int FLASH_BOUNDS    = 6;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/countdown_tick.sv
// Modulo-N counter with synchronous clear and a wrap pulse.
//   clk   : sole clock
//   rst   : synchronous active-high reset
//   clear : forces the count to 0 on the next edge (wins over en)
//   en    : advance the count by one each cycle
//   wrap  : high in the cycle where the count sits at N-1 while enabled,
//           i.e. the next edge returns it to 0
module countdown_tick
  import countdown_led_pkg::*;
#(
  parameter int N = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign wrap = en && (count == LAST);

endmodule

// File: rtl/countdown_led.sv
// Alarm countdown: a rising edge on ring lights the whole LED bar, which
// shrinks from the MSB one LED per TICK_CYCLES, then flashes three times
// (FLASH_HALF cycles per half-period) and pulses done.
//   clk     : sole clock
//   reset_n : synchronous reset, active-high despite the name
//   ring    : alarm trigger level; a rising edge (re)starts the sequence
//   led     : countdown bar / flash pattern
//   busy    : registered, high while not IDLE
//   done    : one-cycle pulse on the edge the sequence returns to IDLE
module countdown_led
  import countdown_led_pkg::*;
#(
  parameter int LED_W       = DEF_LED_W,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int FLASH_HALF  = DEF_FLASH_HALF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ring,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(FLASH_BOUNDS);
  localparam logic [BW-1:0] LAST_BOUND = BW'(FLASH_BOUNDS - 1);
  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  state_t           state, state_nx;
  logic [LED_W-1:0] led_nx;
  logic [BW-1:0]    bcnt, bcnt_nx;
  logic             done_nx;
  logic             busy_nx;
  logic             ring_d;
  logic             start;
  logic             tick_wrap, half_wrap;

  assign start = ring & ~ring_d;

  // Each counter is held at 0 outside its own state, so entering COUNT or
  // FLASH always begins a full period; start also clears them for restarts.
  countdown_tick #(.N(TICK_CYCLES)) u_step (
    .clk   (clk),
    .rst   (reset_n),
    .clear (start || (state != ST_COUNT)),
    .en    (state == ST_COUNT),
    .wrap  (tick_wrap)
  );

  countdown_tick #(.N(FLASH_HALF)) u_flash (
    .clk   (clk),
    .rst   (reset_n),
    .clear (start || (state != ST_FLASH)),
    .en    (state == ST_FLASH),
    .wrap  (half_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state  <= ST_IDLE;
      led    <= '0;
      bcnt   <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      ring_d <= 1'b0;
    end else begin
      state  <= state_nx;
      led    <= led_nx;
      bcnt   <= bcnt_nx;
      done   <= done_nx;
      busy   <= busy_nx;
      ring_d <= ring;
    end
  end

  always_comb begin
    state_nx = state;
    led_nx   = led;
    bcnt_nx  = bcnt;
    done_nx  = 1'b0;
    if (start) begin
      // A fresh rising edge wins over any step or flash boundary.
      state_nx = ST_COUNT;
      led_nx   = '1;
      bcnt_nx  = '0;
    end else begin
      case (state)
        ST_COUNT: begin
          if (tick_wrap) begin
            if (led == LED_ONE) begin
              state_nx = ST_FLASH;
              led_nx   = '1;
              bcnt_nx  = '0;
            end else begin
              led_nx = led >> 1;
            end
          end
        end
        ST_FLASH: begin
          if (half_wrap) begin
            if (bcnt == LAST_BOUND) begin
              state_nx = ST_IDLE;
              led_nx   = '0;
              bcnt_nx  = '0;
              done_nx  = 1'b1;
            end else begin
              bcnt_nx = bcnt + BW'(1);
              led_nx  = ~led;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          led_nx   = '0;
          bcnt_nx  = '0;
        end
      endcase
    end
    busy_nx = (state_nx != ST_IDLE);
  end

endmodule

// File: tb/tb_countdown_led.sv
module tb_countdown_led;

  localparam int LED_W       = 4;
  localparam int TICK_CYCLES = 4;
  localparam int FLASH_HALF  = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             ring = 1'b0;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  countdown_led #(
    .LED_W       (LED_W),
    .TICK_CYCLES (TICK_CYCLES),
    .FLASH_HALF  (FLASH_HALF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ring    (ring),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // Expected led after edges 1..28 of a full sequence (edge 0 lights 1111).
  logic [LED_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int done_cnt;

  initial begin
    exp_q = '{4'hF, 4'hF, 4'hF,
              4'h7, 4'h7, 4'h7, 4'h7,
              4'h3, 4'h3, 4'h3, 4'h3,
              4'h1, 4'h1, 4'h1, 4'h1,
              4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF,
              4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0,
              4'h0};

    // Reset held for 5 cycles with ring low.
    reset_n = 1'b1;
    ring    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_led", 32'(led), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
    end
    reset_n = 1'b0;
    step();
    check("idle_led", 32'(led), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Full sequence from a one-cycle ring pulse.
    ring = 1'b1;
    step();
    ring = 1'b0;
    check("seq_start_led", 32'(led), 32'hF);
    check("seq_start_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 28; k++) begin
      step();
      check($sformatf("seq_led_%0d", k), 32'(led), 32'(exp_q[k-1]));
      check($sformatf("seq_busy_%0d", k), 32'(busy), (k < 28) ? 32'h1 : 32'h0);
      check($sformatf("seq_done_%0d", k), 32'(done), (k == 28) ? 32'h1 : 32'h0);
    end
    step();
    check("seq_done_clear", 32'(done), 32'h0);
    check("seq_end_led", 32'(led), 32'h0);

    // Ring held high for 50 cycles: exactly one sequence.
    ring = 1'b1;
    step();
    check("hold_start_led", 32'(led), 32'hF);
    done_cnt = 0;
    for (int k = 1; k < 50; k++) begin
      step();
      if (done) done_cnt++;
      if (k == 4) check("hold_shift_led", 32'(led), 32'h7);
    end
    check("hold_done_cnt", 32'(done_cnt), 32'h1);
    check("hold_end_busy", 32'(busy), 32'h0);
    check("hold_end_led", 32'(led), 32'h0);
    ring = 1'b0;
    step();
    check("hold_release_busy", 32'(busy), 32'h0);

    // Restart while led = 0011.
    ring = 1'b1;
    step();
    ring = 1'b0;
    check("rs_start_led", 32'(led), 32'hF);
    steps(8);
    check("rs_pre_led", 32'(led), 32'h3);
    ring = 1'b1;
    step();
    ring = 1'b0;
    check("rs_restart_led", 32'(led), 32'hF);
    steps(3);
    check("rs_hold_led", 32'(led), 32'hF);
    step();
    check("rs_shift_led", 32'(led), 32'h7);

    // Into FLASH (edge 18 after restart shows 0000), then reset.
    steps(14);
    check("fl_led", 32'(led), 32'h0);
    check("fl_busy", 32'(busy), 32'h1);
    reset_n = 1'b1;
    step();
    check("fl_rst_led", 32'(led), 32'h0);
    check("fl_rst_busy", 32'(busy), 32'h0);
    check("fl_rst_done", 32'(done), 32'h0);
    reset_n = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done || busy) done_cnt++;
    end
    check("fl_no_done", 32'(done_cnt), 32'h0);

    // Reset wins over ring; ring high right after reset is a rising edge.
    reset_n = 1'b1;
    ring    = 1'b1;
    step();
    check("rp_rst_led", 32'(led), 32'h0);
    check("rp_rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b0;
    step();
    check("rp_first_led", 32'(led), 32'hF);
    check("rp_first_busy", 32'(busy), 32'h1);
    ring = 1'b0;
    steps(3);
    check("rp_pre_bound_led", 32'(led), 32'hF);
    // Start lands on the same edge as the first step boundary.
    ring = 1'b1;
    step();
    ring = 1'b0;
    check("rp_bound_led", 32'(led), 32'hF);
    steps(3);
    check("rp_bound_hold_led", 32'(led), 32'hF);
    step();
    check("rp_bound_shift_led", 32'(led), 32'h7);

    reset_n = 1'b1;
    step();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
